uart_tx_arbiter: RTL and testbench

Round-robin controller that shares one `UART_TX` transmitter between `NUM_REQ` byte sources. Each requester offers bytes over a valid/ready handshake and can lock the transmitter for a multi-byte message. The block sequences the transmitter's `tx_dv_i` pulse, its `tx_active_o` and its `tx_done_o`. It sits between the application-side message producers and the single `UART_TX` instance.

---
 rtl/uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin controller sharing one UART_TX transmitter between
//            NUM_REQ byte sources. A granted requester keeps the transmitter
//            until it sends a byte flagged "last" or until it idles in FETCH
//            for LOCK_TIMEOUT cycles.
// Ports    : clk_i, rst_i                 - clock, sync active-high reset
//            req_valid_i/req_byte_i/
//            req_last_i/req_ready_o       - per-requester byte handshake
//            tx_dv_o, tx_byte_o           - start pulse and byte to UART_TX
//            tx_active_i, tx_done_i       - UART_TX status flags
//            grant_o                      - one-hot current owner
//            busy_o                       - controller not idle
//            timeout_o                    - pulse when a grant is revoked
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_byte_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_dv_o,
  output logic [7:0]             tx_byte_o,
  input  logic                   tx_active_i,
  input  logic                   tx_done_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] c_st_idle       = 3'd0;
  localparam logic [2:0] c_st_fetch      = 3'd1;
  localparam logic [2:0] c_st_wait_start = 3'd2;
  localparam logic [2:0] c_st_wait_done  = 3'd3;
  localparam logic [2:0] c_st_wait_idle  = 3'd4;

  localparam logic [c_idx_w:0]   c_num_req_w = (c_idx_w + 1)'(NUM_REQ);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_oh_lsb    = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic               c_to_en     = (LOCK_TIMEOUT != 0);
  localparam logic [15:0]        c_to_last   = (LOCK_TIMEOUT != 0) ? 16'(LOCK_TIMEOUT - 1) : 16'd0;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [c_idx_w-1:0] r_gidx;
  logic [c_idx_w-1:0] r_rr_ptr;
  logic               r_last;
  logic [15:0]        r_lock_cnt;
  logic               r_tx_dv;
  logic [7:0]         r_tx_byte;
  logic               r_timeout;

  logic               w_any;
  logic [c_idx_w-1:0] w_pick;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [7:0]         w_sel_byte;
  logic               w_xfer;
  logic               w_to_hit;
  logic [c_idx_w-1:0] w_gidx_inc;

  // Rotating priority: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [c_idx_w:0]   v_sum;
    logic [c_idx_w-1:0] v_idx;
    w_any  = 1'b0;
    w_pick = '0;
    v_sum  = '0;
    v_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_sum = {1'b0, r_rr_ptr} + (c_idx_w + 1)'(i);
      if (v_sum >= c_num_req_w) begin
        v_sum = v_sum - c_num_req_w;
      end
      v_idx = v_sum[c_idx_w-1:0];
      if (!w_any && req_valid_i[v_idx]) begin
        w_any  = 1'b1;
        w_pick = v_idx;
      end
    end
  end

  // Handshake signals of the current owner only.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_byte  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == c_idx_w'(i)) begin
        w_sel_valid = req_valid_i[i];
        w_sel_last  = req_last_i[i];
        w_sel_byte  = req_byte_i[8*i +: 8];
      end
    end
  end

  assign w_xfer     = (r_state == c_st_fetch) && w_sel_valid;
  // Counter sits at N-1 on the Nth idle FETCH cycle, so release lands there.
  assign w_to_hit   = c_to_en && (r_lock_cnt == c_to_last);
  assign w_gidx_inc = (r_gidx == c_last_idx) ? '0 : r_gidx + c_idx_w'(1);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:       if (w_any) w_state_nxt = c_st_fetch;
      // A transfer on the timeout cycle takes priority over the release.
      c_st_fetch:      if (w_xfer) w_state_nxt = c_st_wait_start;
                       else if (w_to_hit) w_state_nxt = c_st_idle;
      c_st_wait_start: if (tx_active_i) w_state_nxt = c_st_wait_done;
      c_st_wait_done:  if (tx_done_i) w_state_nxt = c_st_wait_idle;
      // Waiting for done to drop keeps a long done pulse from re-triggering.
      c_st_wait_idle:  if (!tx_done_i) w_state_nxt = r_last ? c_st_idle : c_st_fetch;
      default:         w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o = '0;
    busy_o      = (r_state != c_st_idle);
    if (r_state == c_st_fetch) begin
      req_ready_o = r_grant;
    end
  end

  // Grant, pointer and transmitter datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_last     <= 1'b0;
      r_lock_cnt <= 16'd0;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_dv   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_any) begin
            r_grant    <= c_oh_lsb << w_pick;
            r_gidx     <= w_pick;
            r_lock_cnt <= 16'd0;
          end
        end
        c_st_fetch: begin
          if (w_xfer) begin
            r_tx_byte  <= w_sel_byte;
            r_tx_dv    <= 1'b1;
            r_last     <= w_sel_last;
            r_lock_cnt <= 16'd0;
          end else if (w_to_hit) begin
            r_grant    <= '0;
            r_rr_ptr   <= w_gidx_inc;
            r_timeout  <= 1'b1;
            r_lock_cnt <= 16'd0;
          end else begin
            r_lock_cnt <= r_lock_cnt + 16'd1;
          end
        end
        c_st_wait_idle: begin
          if (!tx_done_i && r_last) begin
            r_grant  <= '0;
            r_rr_ptr <= w_gidx_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_o   = r_grant;
  assign tx_dv_o   = r_tx_dv;
  assign tx_byte_o = r_tx_byte;
  assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter (4 requesters,
//            lock timeout of 8) with a small behavioural UART_TX model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int LT    = 8;
  localparam int FRAME = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [8*NR-1:0] req_byte = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic [NR-1:0] grant;
  logic          busy;
  logic          timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_byte_i  (req_byte),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_dv_o     (tx_dv),
    .tx_byte_o   (tx_byte),
    .tx_active_i (tx_active),
    .tx_done_i   (tx_done),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  // Behavioural transmitter: active for FRAME cycles, then done for m_done_len.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_done_len = 1;
  always @(posedge clk) begin
    if (rst) begin
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      m_phase   <= 0;
      m_cnt     <= 0;
    end else begin
      case (m_phase)
        0: if (tx_dv) begin tx_active <= 1'b1; m_phase <= 1; m_cnt <= FRAME - 1; end
        1: if (m_cnt == 0) begin
             tx_active <= 1'b0; tx_done <= 1'b1; m_phase <= 2; m_cnt <= m_done_len - 1;
           end else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 0) begin tx_done <= 1'b0; m_phase <= 0; end
                 else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  // Event logs: sent bytes, grant sequence, timeouts, start pulses while busy.
  logic [7:0]    dv_q[$];
  logic [NR-1:0] gnt_q[$];
  logic [NR-1:0] prev_gnt = '0;
  int dup_dv = 0;
  int to_cnt = 0;
  always @(negedge clk) begin
    if (tx_dv) begin
      dv_q.push_back(tx_byte);
      if (m_phase != 0) dup_dv <= dup_dv + 1;
    end
    if (timeout) to_cnt <= to_cnt + 1;
    if (grant != '0 && grant != prev_gnt) gnt_q.push_back(grant);
    prev_gnt <= grant;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    req_last  = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick;
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_ready(input string tag, input int idx);
    for (int i = 0; i < 200 && !req_ready[idx]; i++) tick;
    chk(tag, {31'd0, req_ready[idx]}, 32'd1);
  endtask

  // Returns on the sample where tx_done has just fallen.
  task automatic wait_done_fall(input string tag);
    int  n;
    logic seen;
    n = 0;
    while (!tx_done && n < 100) begin tick; n++; end
    seen = tx_done;
    while (tx_done && n < 200) begin tick; n++; end
    chk(tag, {30'd0, seen, tx_done}, 32'd2);
  endtask

  // Offer one byte from IDLE and drop valid on the cycle after acceptance.
  task automatic send_first(input string tag, input int idx, input logic [7:0] b, input logic l);
    req_byte[idx*8 +: 8] = b;
    req_last[idx]  = l;
    req_valid[idx] = 1'b1;
    wait_ready(tag, idx);
    tick;
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, gbase, dup0, to0, n, k, early;
    logic [7:0] tbl[3];
    logic acc;

    // ---------------- reset state ----------------
    tick; tick;
    chk("rst_grant",   {28'd0, grant}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_dv",      {31'd0, tx_dv}, 32'd0);
    chk("rst_ready",   {28'd0, req_ready}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_byte",    {24'd0, tx_byte}, 32'd0);
    rst = 1'b0;

    // ---------------- single request ----------------
    base = dv_q.size();
    req_byte[23:16] = 8'hA5;
    req_last[2]  = 1'b1;
    req_valid[2] = 1'b1;
    chk("t1_c0_ready", {28'd0, req_ready}, 32'd0);
    tick;
    chk("t1_c1_grant", {28'd0, grant}, 32'h4);
    chk("t1_c1_ready", {28'd0, req_ready}, 32'h4);
    chk("t1_c1_dv",    {31'd0, tx_dv}, 32'd0);
    tick;
    req_valid[2] = 1'b0;
    chk("t1_c2_dv",    {31'd0, tx_dv}, 32'd1);
    chk("t1_c2_byte",  {24'd0, tx_byte}, 32'hA5);
    tick;
    chk("t1_c3_dv",    {31'd0, tx_dv}, 32'd0);
    wait_done_fall("t1_done_fall");
    chk("t1_grant_held", {28'd0, grant}, 32'h4);
    tick;
    chk("t1_grant_rel", {28'd0, grant}, 32'd0);
    chk("t1_busy_rel",  {31'd0, busy}, 32'd0);
    chk("t1_byte_hold", {24'd0, tx_byte}, 32'hA5);
    chk("t1_dv_count",  dv_q.size() - base, 32'd1);

    // ---------------- round-robin ----------------
    do_reset;
    base = dv_q.size(); gbase = gnt_q.size(); dup0 = dup_dv;
    req_byte[7:0] = 8'h30; req_byte[31:24] = 8'h33;
    req_last[0] = 1'b1; req_last[3] = 1'b1;
    req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    n = 0;
    while (dv_q.size() - base < 4 && n < 400) begin tick; n++; end
    req_valid = '0;
    chk("t2_dv_count", dv_q.size() - base, 32'd4);
    wait_idle("t2_idle");
    chk("t2_gnt_n", gnt_q.size() - gbase, 32'd4);
    chk("t2_gnt0", {28'd0, gnt_q[gbase]},     32'h1);
    chk("t2_gnt1", {28'd0, gnt_q[gbase + 1]}, 32'h8);
    chk("t2_gnt2", {28'd0, gnt_q[gbase + 2]}, 32'h1);
    chk("t2_gnt3", {28'd0, gnt_q[gbase + 3]}, 32'h8);
    chk("t2_byte0", {24'd0, dv_q[base]},     32'h30);
    chk("t2_byte1", {24'd0, dv_q[base + 1]}, 32'h33);
    chk("t2_byte3", {24'd0, dv_q[base + 3]}, 32'h33);
    chk("t2_dup_dv", dup_dv - dup0, 32'd0);

    // ---------------- locked message, long done pulse ----------------
    do_reset;
    m_done_len = 2;
    base = dv_q.size(); gbase = gnt_q.size(); dup0 = dup_dv;
    tbl[0] = 8'h10; tbl[1] = 8'h11; tbl[2] = 8'h12;
    req_byte[15:8] = tbl[0]; req_last[1] = 1'b0; req_valid[1] = 1'b1;
    tick;
    req_byte[7:0] = 8'h05; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    k = 0; n = 0; early = 0;
    while (dv_q.size() - base < 4 && n < 400) begin
      acc = req_ready[1] & req_valid[1];
      if (req_ready[0] && (dv_q.size() - base) < 3) early = 1;
      tick; n++;
      if (acc) begin
        k++;
        if (k < 3) begin req_byte[15:8] = tbl[k]; req_last[1] = (k == 2); end
        else req_valid[1] = 1'b0;
      end
    end
    req_valid = '0;
    wait_idle("t3_idle");
    chk("t3_ready0_early", early, 32'd0);
    chk("t3_dv_count", dv_q.size() - base, 32'd4);
    chk("t3_byte0", {24'd0, dv_q[base]},     32'h10);
    chk("t3_byte1", {24'd0, dv_q[base + 1]}, 32'h11);
    chk("t3_byte2", {24'd0, dv_q[base + 2]}, 32'h12);
    chk("t3_byte3", {24'd0, dv_q[base + 3]}, 32'h05);
    chk("t3_gnt_n", gnt_q.size() - gbase, 32'd2);
    chk("t3_gnt0", {28'd0, gnt_q[gbase]},     32'h2);
    chk("t3_gnt1", {28'd0, gnt_q[gbase + 1]}, 32'h1);
    chk("t3_dup_dv", dup_dv - dup0, 32'd0);
    m_done_len = 1;

    // ---------------- lock timeout ----------------
    do_reset;
    to0 = to_cnt;
    req_byte[23:16] = 8'h22; req_last[2] = 1'b1; req_valid[2] = 1'b1;
    send_first("t4_ready_a", 1, 8'h20, 1'b0);
    wait_ready("t4_fetch", 1);
    early = 0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      if (timeout) early = 1;
    end
    chk("t4_to_early", early, 32'd0);
    chk("t4_grant_hold", {28'd0, grant}, 32'h2);
    tick;
    chk("t4_to_pulse", {31'd0, timeout}, 32'd1);
    chk("t4_grant_rel", {28'd0, grant}, 32'd0);
    chk("t4_busy_rel",  {31'd0, busy}, 32'd0);
    tick;
    chk("t4_to_clear", {31'd0, timeout}, 32'd0);
    chk("t4_next_grant", {28'd0, grant}, 32'h4);
    tick;
    chk("t4_next_dv",   {31'd0, tx_dv}, 32'd1);
    chk("t4_next_byte", {24'd0, tx_byte}, 32'h22);
    req_valid[2] = 1'b0;
    wait_idle("t4_idle");

    // Transfer on the timeout cycle wins over the release.
    send_first("t4b_ready_a", 1, 8'h40, 1'b0);
    wait_ready("t4b_fetch", 1);
    for (int i = 1; i <= 7; i++) tick;
    req_byte[15:8] = 8'h41; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    chk("t4b_ready", {28'd0, req_ready}, 32'h2);
    tick;
    req_valid[1] = 1'b0;
    chk("t4b_no_to", {31'd0, timeout}, 32'd0);
    chk("t4b_dv",    {31'd0, tx_dv}, 32'd1);
    chk("t4b_byte",  {24'd0, tx_byte}, 32'h41);
    wait_idle("t4b_idle");
    chk("t4_to_total", to_cnt - to0, 32'd1);

    // ---------------- reset mid-frame ----------------
    do_reset;
    send_first("t5_ready_a", 0, 8'h55, 1'b1);
    for (int i = 0; i < 50 && !tx_active; i++) tick;
    tick;
    chk("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick;
    chk("t5_busy",  {31'd0, busy}, 32'd0);
    chk("t5_grant", {28'd0, grant}, 32'd0);
    chk("t5_dv",    {31'd0, tx_dv}, 32'd0);
    chk("t5_ready", {28'd0, req_ready}, 32'd0);
    chk("t5_byte",  {24'd0, tx_byte}, 32'd0);
    rst = 1'b0;
    send_first("t5_ready_b", 0, 8'h66, 1'b1);
    chk("t5_dv2",   {31'd0, tx_dv}, 32'd1);
    chk("t5_byte2", {24'd0, tx_byte}, 32'h66);
    wait_idle("t5_idle");
    chk("t5_grant_end", {28'd0, grant}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
